// File: rtl/rf_2r1w_param_if.sv
// rtl/rf_2r1w_param_if.sv - read/write/clear bundle for the 2R1W register file
interface rf_2r1w_param_if #(
  parameter int WIDTH  = 4,
  parameter int ADDR_W = 2
);
  logic              rea;
  logic              reb;
  logic [ADDR_W-1:0] raa;
  logic [ADDR_W-1:0] rab;
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [WIDTH-1:0]  din;
  logic              clr;
  logic [WIDTH-1:0]  douta;
  logic [WIDTH-1:0]  doutb;
  logic              valida;
  logic              validb;
  logic              busy;

  // Controller side: issues reads, writes and clear requests.
  modport master (
    output rea, reb, raa, rab, we, wa, din, clr,
    input  douta, doutb, valida, validb, busy
  );

  // Register file side.
  modport slave (
    input  rea, reb, raa, rab, we, wa, din, clr,
    output douta, doutb, valida, validb, busy
  );
endinterface

// File: rtl/rf_2r1w_param.sv
// rtl/rf_2r1w_param.sv - parametrised 2-read/1-write register file with bypass and bulk clear
module rf_2r1w_param #(
  parameter int WIDTH    = 4,
  parameter int ADDR_W   = 2,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  rf_2r1w_param_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             valid;
  } rd_t;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              busy_q, busy_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  mem_d [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [WIDTH-1:0]  douta_q, douta_d;
  logic [WIDTH-1:0]  doutb_q, doutb_d;
  logic              valida_q, valida_d;
  logic              validb_q, validb_d;

  logic clr_accept;
  logic wr_ok;
  logic rd_blocked;
  rd_t  rd_a;
  rd_t  rd_b;

  // Resolve one read port: disable, clear blocking, hard zero, bypass, array.
  function automatic rd_t read_port(
    input logic              en,
    input logic [ADDR_W-1:0] addr,
    input logic              blocked,
    input logic              wr_hit_ok,
    input logic [ADDR_W-1:0] waddr,
    input logic [WIDTH-1:0]  wdata,
    input logic [WIDTH-1:0]  arr_data,
    input logic              arr_valid
  );
    rd_t r;
    r.data  = '0;
    r.valid = 1'b0;
    if (!en || blocked) begin
      r.data  = '0;
      r.valid = 1'b0;
    end else if (ZERO_REG && (addr == '0)) begin
      r.data  = '0;
      r.valid = 1'b1;
    end else if (wr_hit_ok && (waddr == addr)) begin
      r.data  = wdata;
      r.valid = 1'b1;
    end else begin
      r.data  = arr_data;
      r.valid = arr_valid;
    end
    return r;
  endfunction

  // Qualify the requests: clear only starts from IDLE and beats a same-cycle write.
  always_comb begin
    clr_accept = (state_q == IDLE) && bus.clr;
    wr_ok      = (state_q == IDLE) && bus.we && !bus.clr
                 && !(ZERO_REG && (bus.wa == '0));
    rd_blocked = (state_q == CLEAR) || clr_accept;
  end

  // Clear sequencer and array write path.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    busy_d  = busy_q;
    mem_d   = mem_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (clr_accept) begin
          state_d = CLEAR;
          ptr_d   = '0;
          busy_d  = 1'b1;
        end else if (wr_ok) begin
          mem_d[bus.wa]   = bus.din;
          valid_d[bus.wa] = 1'b1;
        end
      end
      CLEAR: begin
        mem_d[ptr_q]   = '0;
        valid_d[ptr_q] = 1'b0;
        ptr_d          = ptr_q + 1'b1;
        if (ptr_q == LAST_PTR) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Next values of both registered read ports.
  always_comb begin
    rd_a = read_port(bus.rea, bus.raa, rd_blocked, wr_ok, bus.wa, bus.din,
                     mem_q[bus.raa], valid_q[bus.raa]);
    rd_b = read_port(bus.reb, bus.rab, rd_blocked, wr_ok, bus.wa, bus.din,
                     mem_q[bus.rab], valid_q[bus.rab]);
    douta_d  = rd_a.data;
    valida_d = rd_a.valid;
    doutb_d  = rd_b.data;
    validb_d = rd_b.valid;
  end

  // State, array and output registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      busy_q   <= 1'b0;
      valid_q  <= '0;
      douta_q  <= '0;
      doutb_q  <= '0;
      valida_q <= 1'b0;
      validb_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      douta_q  <= douta_d;
      doutb_q  <= doutb_d;
      valida_q <= valida_d;
      validb_q <= validb_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign bus.douta  = douta_q;
  assign bus.doutb  = doutb_q;
  assign bus.valida = valida_q;
  assign bus.validb = validb_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_rf_2r1w_param.sv
// tb/tb_rf_2r1w_param.sv - randomized and directed checks against a behavioural register file model
module tb_rf_2r1w_param;
  localparam int WIDTH  = 4;
  localparam int ADDR_W = 2;
  localparam int DEPTH  = 4;

  logic clk;
  logic rst;

  rf_2r1w_param_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) ifn ();
  rf_2r1w_param_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) ifz ();

  rf_2r1w_param #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .ZERO_REG(1'b0)) dut_n (
    .clk(clk), .rst(rst), .bus(ifn)
  );
  rf_2r1w_param #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .ZERO_REG(1'b1)) dut_z (
    .clk(clk), .rst(rst), .bus(ifz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // stimulus shared by both instances
  logic       s_rea, s_reb, s_we, s_clr;
  logic [1:0] s_raa, s_rab, s_wa;
  logic [3:0] s_din;

  // behavioural model: index 0 = plain, 1 = hard-wired zero register
  int m_mem  [2][DEPTH];
  bit m_val  [2][DEPTH];
  int m_left [2];
  int e_da [2], e_db [2];
  bit e_va [2], e_vb [2], e_busy [2];

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_left[k] = 0;
      e_da[k] = 0; e_db[k] = 0; e_va[k] = 0; e_vb[k] = 0; e_busy[k] = 0;
      for (int i = 0; i < DEPTH; i++) begin
        m_mem[k][i] = 0;
        m_val[k][i] = 0;
      end
    end
  endtask

  // Clearing is modelled as "everything is zero once accepted, busy for DEPTH cycles";
  // reads and writes are blocked during that window, so the order of zeroing is invisible.
  task automatic model_step(input int k);
    bit busy_now, acc, wok, zr;
    zr       = (k == 1);
    busy_now = (m_left[k] > 0);
    acc      = !busy_now && s_clr;
    wok      = !busy_now && !s_clr && s_we && !(zr && s_wa == 0);
    if (!s_rea || busy_now || acc) begin e_da[k] = 0; e_va[k] = 0; end
    else if (zr && s_raa == 0) begin e_da[k] = 0; e_va[k] = 1; end
    else if (wok && s_wa == s_raa) begin e_da[k] = s_din; e_va[k] = 1; end
    else begin e_da[k] = m_mem[k][s_raa]; e_va[k] = m_val[k][s_raa]; end
    if (!s_reb || busy_now || acc) begin e_db[k] = 0; e_vb[k] = 0; end
    else if (zr && s_rab == 0) begin e_db[k] = 0; e_vb[k] = 1; end
    else if (wok && s_wa == s_rab) begin e_db[k] = s_din; e_vb[k] = 1; end
    else begin e_db[k] = m_mem[k][s_rab]; e_vb[k] = m_val[k][s_rab]; end
    if (busy_now) m_left[k] = m_left[k] - 1;
    if (acc) begin
      m_left[k] = DEPTH;
      for (int i = 0; i < DEPTH; i++) begin
        m_mem[k][i] = 0;
        m_val[k][i] = 0;
      end
    end
    if (wok) begin
      m_mem[k][s_wa] = s_din;
      m_val[k][s_wa] = 1;
    end
    e_busy[k] = (m_left[k] > 0);
  endtask

  task automatic check_model();
    chk("n.douta",  ifn.douta,  e_da[0]);
    chk("n.valida", ifn.valida, e_va[0]);
    chk("n.doutb",  ifn.doutb,  e_db[0]);
    chk("n.validb", ifn.validb, e_vb[0]);
    chk("n.busy",   ifn.busy,   e_busy[0]);
    chk("z.douta",  ifz.douta,  e_da[1]);
    chk("z.valida", ifz.valida, e_va[1]);
    chk("z.doutb",  ifz.doutb,  e_db[1]);
    chk("z.validb", ifz.validb, e_vb[1]);
    chk("z.busy",   ifz.busy,   e_busy[1]);
  endtask

  task automatic apply();
    ifn.rea = s_rea; ifn.reb = s_reb; ifn.raa = s_raa; ifn.rab = s_rab;
    ifn.we  = s_we;  ifn.wa  = s_wa;  ifn.din = s_din; ifn.clr = s_clr;
    ifz.rea = s_rea; ifz.reb = s_reb; ifz.raa = s_raa; ifz.rab = s_rab;
    ifz.we  = s_we;  ifz.wa  = s_wa;  ifz.din = s_din; ifz.clr = s_clr;
  endtask

  task automatic idle_stim();
    s_rea = 0; s_reb = 0; s_raa = 0; s_rab = 0;
    s_we = 0; s_wa = 0; s_din = 0; s_clr = 0;
  endtask

  // One clock: drive at the falling edge, advance the model, check after the rising edge.
  task automatic cyc();
    @(negedge clk);
    apply();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    check_model();
  endtask

  initial begin
    int busy_cnt;
    idle_stim();
    apply();
    rst = 1'b1;
    model_reset();
    #12;
    chk("rst.douta",  ifn.douta,  0);
    chk("rst.doutb",  ifn.doutb,  0);
    chk("rst.valida", ifn.valida, 0);
    chk("rst.validb", ifn.validb, 0);
    chk("rst.busy",   ifn.busy,   0);
    chk("rst.z.busy", ifz.busy,   0);
    @(negedge clk);
    rst = 1'b0;

    // reads of an unwritten file
    s_rea = 1; s_reb = 1; s_raa = 1; s_rab = 2;
    cyc();
    chk("empty.douta",  ifn.douta,  0);
    chk("empty.validb", ifn.validb, 0);

    // write then read
    idle_stim(); s_we = 1; s_wa = 2; s_din = 4'hA;
    cyc();
    idle_stim(); s_rea = 1; s_raa = 2;
    cyc();
    chk("wr.douta",  ifn.douta,  4'hA);
    chk("wr.valida", ifn.valida, 1);

    // write-first bypass on both ports
    idle_stim(); s_we = 1; s_wa = 3; s_din = 4'h5;
    s_rea = 1; s_reb = 1; s_raa = 3; s_rab = 3;
    cyc();
    chk("byp.douta", ifn.douta, 4'h5);
    chk("byp.doutb", ifn.doutb, 4'h5);
    chk("byp.validb", ifn.validb, 1);

    // hard-wired zero register
    idle_stim(); s_we = 1; s_wa = 0; s_din = 4'h7;
    cyc();
    idle_stim(); s_rea = 1; s_raa = 0;
    cyc();
    chk("zr.z.douta",  ifz.douta,  0);
    chk("zr.z.valida", ifz.valida, 1);
    chk("zr.n.douta",  ifn.douta,  4'h7);
    idle_stim(); s_we = 1; s_wa = 0; s_din = 4'h3; s_rea = 1; s_raa = 0;
    cyc();
    chk("zrbyp.z.douta", ifz.douta, 0);
    chk("zrbyp.n.douta", ifn.douta, 4'h3);

    // fill, clear, write during busy
    for (int i = 0; i < DEPTH; i++) begin
      idle_stim(); s_we = 1; s_wa = 2'(i); s_din = 4'(i + 8);
      cyc();
    end
    idle_stim(); s_clr = 1;
    cyc();
    busy_cnt = ifn.busy ? 1 : 0;
    s_clr = 1; s_we = 1; s_wa = 1; s_din = 4'hF;
    for (int t = 0; t < 10 && ifn.busy; t++) begin
      cyc();
      if (ifn.busy) busy_cnt++;
    end
    chk("clr.busy_cycles", busy_cnt, DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      idle_stim(); s_rea = 1; s_reb = 1; s_raa = 2'(i); s_rab = 2'(i);
      cyc();
      chk("clr.douta", ifn.douta, 0);
      chk("clr.valida", ifn.valida, 0);
    end

    // asynchronous reset during the second clear cycle
    idle_stim(); s_clr = 1;
    cyc();
    idle_stim();
    cyc();
    #2;
    rst = 1'b1;
    #1;
    chk("arst.n.busy", ifn.busy, 0);
    chk("arst.z.busy", ifz.busy, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    idle_stim(); s_clr = 1; s_we = 1; s_wa = 1; s_din = 4'h9;
    cyc();
    chk("clrwe.busy", ifn.busy, 1);
    idle_stim();
    for (int t = 0; t < DEPTH; t++) cyc();
    s_rea = 1; s_raa = 1;
    cyc();
    chk("clrwe.douta",  ifn.douta,  0);
    chk("clrwe.valida", ifn.valida, 0);

    // randomized traffic
    for (int t = 0; t < 400; t++) begin
      s_rea = 1'($urandom_range(0, 3) != 0);
      s_reb = 1'($urandom_range(0, 3) != 0);
      s_raa = 2'($urandom);
      s_rab = 2'($urandom);
      s_we  = 1'($urandom_range(0, 1));
      s_wa  = 2'($urandom);
      s_din = 4'($urandom);
      s_clr = 1'($urandom_range(0, 15) == 0);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
